incr_arbiter: RTL

INCR_ARBITER -- requirements
Module: incr_arbiter

---
 rtl/incr_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/incr_arbiter.sv
// Request arbiter that grants one requester, increments its operand and returns the result.
// Define ARB_RR_EN for round-robin arbitration; the default build uses fixed lowest-index priority.
module incr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DW    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] op_in,
    output logic [N_REQ-1:0]    gnt,
    output logic                busy,
    output logic                res_valid,
    output logic [2:0]          res_id,
    output logic [DW-1:0]       res_data,
    output logic                res_carry
);

    typedef enum logic [1:0] {StIdle, StGrant, StExec, StDone} state_e;

    localparam logic [DW:0] One = 1;

    state_e        state_q, state_d;
    logic [2:0]    winner_q, winner_d;
    logic [DW-1:0] op_q, op_d;
    logic [2:0]    res_id_q, res_id_d;
    logic [DW-1:0] res_data_q, res_data_d;
    logic          res_carry_q, res_carry_d;
    logic [2:0]    pick_idx;
    logic [DW-1:0] op_sel;
    logic [DW:0]   sum;

`ifdef ARB_RR_EN
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] any_idx, hi_idx;
    logic       hi_found;

    // Lowest set bit at or above the pointer, else wrap to the lowest set bit overall.
    always_comb begin
        any_idx  = '0;
        hi_idx   = '0;
        hi_found = 1'b0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                any_idx = 3'(i);
                if (3'(i) >= ptr_q) begin
                    hi_idx   = 3'(i);
                    hi_found = 1'b1;
                end
            end
        end
        pick_idx = hi_found ? hi_idx : any_idx;
    end
`else
    always_comb begin
        pick_idx = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick_idx = 3'(i);
            end
        end
    end
`endif

    always_comb begin
        op_sel = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (winner_q == 3'(i)) begin
                op_sel = op_in[i*DW +: DW];
            end
        end
    end

    assign sum = {1'b0, op_q} + One;

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        op_d        = op_q;
        res_id_d    = res_id_q;
        res_data_d  = res_data_q;
        res_carry_d = res_carry_q;
`ifdef ARB_RR_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d  = StGrant;
                    winner_d = pick_idx;
`ifdef ARB_RR_EN
                    ptr_d    = (pick_idx == 3'(N_REQ - 1)) ? 3'd0 : pick_idx + 3'd1;
`endif
                end
            end
            StGrant: begin
                state_d = StExec;
                op_d    = op_sel;
            end
            StExec: begin
                state_d     = StDone;
                res_id_d    = winner_q;
                res_data_d  = sum[DW-1:0];
                res_carry_d = sum[DW];
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            winner_q    <= '0;
            op_q        <= '0;
            res_id_q    <= '0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
`ifdef ARB_RR_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            op_q        <= op_d;
            res_id_q    <= res_id_d;
            res_data_q  <= res_data_d;
            res_carry_q <= res_carry_d;
`ifdef ARB_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            gnt[i] = (state_q == StGrant) && (winner_q == 3'(i));
        end
    end

    assign busy      = (state_q != StIdle);
    assign res_valid = (state_q == StDone);
    assign res_id    = res_id_q;
    assign res_data  = res_data_q;
    assign res_carry = res_carry_q;

endmodule
